// File: rtl/kianv_qspi_pkg.sv
// Shared definitions for the QSPI pad arbiter: FSM states, owner encoding and
// the width of the inter-ownership gap counter.
package kianv_qspi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  localparam logic OWNER_RAM = 1'b0;
  localparam logic OWNER_NOR = 1'b1;

  localparam int unsigned GAP_CNT_W = 4;

endpackage

// File: rtl/qspi_bus_arbiter_if.sv
// Bundle of the arbiter's request/grant, master pin and pad signals.
interface qspi_bus_arbiter_if;
  logic       req0;
  logic       gnt0;
  logic       req1;
  logic       gnt1;
  logic       m0_ce_n;
  logic       m0_sclk;
  logic [3:0] m0_sio_o;
  logic [3:0] m0_sio_oe;
  logic       m1_ce_n;
  logic       m1_sclk;
  logic [3:0] m1_sio_o;
  logic [3:0] m1_sio_oe;
  logic       ce0;
  logic       sclk_ram;
  logic       ce1;
  logic       sclk_nor;
  logic [3:0] sio_o;
  logic [3:0] sio_oe;
  logic       busy;
  logic       err;

  modport slave (
    input  req0, req1,
    input  m0_ce_n, m0_sclk, m0_sio_o, m0_sio_oe,
    input  m1_ce_n, m1_sclk, m1_sio_o, m1_sio_oe,
    output gnt0, gnt1,
    output ce0, sclk_ram, ce1, sclk_nor, sio_o, sio_oe,
    output busy, err
  );

  modport master (
    output req0, req1,
    output m0_ce_n, m0_sclk, m0_sio_o, m0_sio_oe,
    output m1_ce_n, m1_sclk, m1_sio_o, m1_sio_oe,
    input  gnt0, gnt1,
    input  ce0, sclk_ram, ce1, sclk_nor, sio_o, sio_oe,
    input  busy, err
  );
endinterface

// File: rtl/qspi_bus_arbiter.sv
// Two-master arbiter for shared QSPI pads (PSRAM / NOR): round-robin on ties,
// no preemption, programmable idle gap between ownerships, sticky error flag.
module qspi_bus_arbiter
  import kianv_qspi_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0,
  output logic       gnt0,
  input  logic       req1,
  output logic       gnt1,
  input  logic       m0_ce_n,
  input  logic       m0_sclk,
  input  logic [3:0] m0_sio_o,
  input  logic [3:0] m0_sio_oe,
  input  logic       m1_ce_n,
  input  logic       m1_sclk,
  input  logic [3:0] m1_sio_o,
  input  logic [3:0] m1_sio_oe,
  output logic       ce0,
  output logic       sclk_ram,
  output logic       ce1,
  output logic       sclk_nor,
  output logic [3:0] sio_o,
  output logic [3:0] sio_oe,
  output logic       busy,
  output logic       err
);

  localparam logic [GAP_CNT_W-1:0] GAP_INIT = GAP_CNT_W'(GAP_CYCLES);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(1);

  arb_state_e           state_q, state_d;
  logic                 last_owner_q, last_owner_d;
  logic [GAP_CNT_W-1:0] cnt_q, cnt_d;
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic                 err_q, err_d;
  logic                 viol0, viol1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_NOR;
      cnt_q        <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && (!req1 || last_owner_q == OWNER_NOR)) begin
          state_d      = ST_OWN0;
          last_owner_d = OWNER_RAM;
        end else if (req1) begin
          state_d      = ST_OWN1;
          last_owner_d = OWNER_NOR;
        end
      end
      ST_OWN0, ST_OWN1: begin
        // Release is evaluated only on the owner's own request; the other
        // master's request waits for IDLE even if it rose this very cycle.
        if ((state_q == ST_OWN0 && !req0) || (state_q == ST_OWN1 && !req1)) begin
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_INIT;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grants are flops loaded from the next state so they never glitch.
  assign gnt0_d = (state_d == ST_OWN0);
  assign gnt1_d = (state_d == ST_OWN1);

  assign viol0 = !gnt0_q && !req0 && (!m0_ce_n || (|m0_sio_oe));
  assign viol1 = !gnt1_q && !req1 && (!m1_ce_n || (|m1_sio_oe));
  assign err_d = err_q | viol0 | viol1;

  always_comb begin
    ce0      = 1'b1;
    sclk_ram = 1'b0;
    ce1      = 1'b1;
    sclk_nor = 1'b0;
    sio_o    = '0;
    sio_oe   = '0;
    unique case (state_q)
      ST_OWN0: begin
        ce0      = m0_ce_n;
        sclk_ram = m0_sclk;
        sio_o    = m0_sio_o;
        sio_oe   = m0_sio_oe;
      end
      ST_OWN1: begin
        ce1      = m1_ce_n;
        sclk_nor = m1_sclk;
        sio_o    = m1_sio_o;
        sio_oe   = m1_sio_oe;
      end
      default: ;
    endcase
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Randomized and directed checks of qspi_bus_arbiter (GAP_CYCLES=2 and 0)
// against a cycle-level ownership model kept in the bench.
module tb_qspi_bus_arbiter;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  qspi_bus_arbiter_if bus ();
  qspi_bus_arbiter_if bus_z ();

  initial clk = 1'b0;
  always #5 clk = ~clk;

  qspi_bus_arbiter #(.GAP_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn),
    .req0(bus.req0), .gnt0(bus.gnt0), .req1(bus.req1), .gnt1(bus.gnt1),
    .m0_ce_n(bus.m0_ce_n), .m0_sclk(bus.m0_sclk), .m0_sio_o(bus.m0_sio_o), .m0_sio_oe(bus.m0_sio_oe),
    .m1_ce_n(bus.m1_ce_n), .m1_sclk(bus.m1_sclk), .m1_sio_o(bus.m1_sio_o), .m1_sio_oe(bus.m1_sio_oe),
    .ce0(bus.ce0), .sclk_ram(bus.sclk_ram), .ce1(bus.ce1), .sclk_nor(bus.sclk_nor),
    .sio_o(bus.sio_o), .sio_oe(bus.sio_oe), .busy(bus.busy), .err(bus.err)
  );

  qspi_bus_arbiter #(.GAP_CYCLES(0)) dut_z (
    .clk(clk), .resetn(resetn),
    .req0(bus.req0), .gnt0(bus_z.gnt0), .req1(bus.req1), .gnt1(bus_z.gnt1),
    .m0_ce_n(bus.m0_ce_n), .m0_sclk(bus.m0_sclk), .m0_sio_o(bus.m0_sio_o), .m0_sio_oe(bus.m0_sio_oe),
    .m1_ce_n(bus.m1_ce_n), .m1_sclk(bus.m1_sclk), .m1_sio_o(bus.m1_sio_o), .m1_sio_oe(bus.m1_sio_oe),
    .ce0(bus_z.ce0), .sclk_ram(bus_z.sclk_ram), .ce1(bus_z.ce1), .sclk_nor(bus_z.sclk_nor),
    .sio_o(bus_z.sio_o), .sio_oe(bus_z.sio_oe), .busy(bus_z.busy), .err(bus_z.err)
  );

  // Model per instance: owner -1 = nobody; gap_left = idle cycles still to run.
  int gap_cfg [2] = '{2, 0};
  int m_owner [2];
  int m_gap   [2];
  int m_last  [2];
  bit m_err   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_gap[k]   = 0;
      m_last[k]  = 1;
      m_err[k]   = 1'b0;
    end
  endtask

  task automatic model_step();
    bit r0, r1, bad0, bad1;
    r0 = bus.req0;
    r1 = bus.req1;
    for (int k = 0; k < 2; k++) begin
      bad0 = (m_owner[k] != 0) && !r0 && (!bus.m0_ce_n || bus.m0_sio_oe != 4'h0);
      bad1 = (m_owner[k] != 1) && !r1 && (!bus.m1_ce_n || bus.m1_sio_oe != 4'h0);
      if (bad0 || bad1) m_err[k] = 1'b1;
      if (m_owner[k] >= 0) begin
        if ((m_owner[k] == 0 && !r0) || (m_owner[k] == 1 && !r1)) begin
          m_owner[k] = -1;
          m_gap[k]   = gap_cfg[k];
        end
      end else if (m_gap[k] > 0) begin
        m_gap[k] = m_gap[k] - 1;
      end else if (r0 && r1) begin
        m_owner[k] = 1 - m_last[k];
        m_last[k]  = m_owner[k];
      end else if (r0 || r1) begin
        m_owner[k] = r0 ? 0 : 1;
        m_last[k]  = m_owner[k];
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.m0_ce_n = 1'b1; bus.m0_sclk = 1'b0; bus.m0_sio_o = 4'h0; bus.m0_sio_oe = 4'h0;
    bus.m1_ce_n = 1'b1; bus.m1_sclk = 1'b0; bus.m1_sio_o = 4'h0; bus.m1_sio_oe = 4'h0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    idle_inputs();
    #12;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    idle_inputs();
    #3;
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: gnt0=%b gnt1=%b busy=%b err=%b required 0 0 0 0",
               bus.gnt0, bus.gnt1, bus.busy, bus.err);
    end
    checks++;
    if (bus.ce0 !== 1'b1 || bus.ce1 !== 1'b1 || bus.sclk_ram !== 1'b0 || bus.sclk_nor !== 1'b0 ||
        bus.sio_o !== 4'h0 || bus.sio_oe !== 4'h0) begin
      failures++;
      $display("FAIL reset_pads: ce0=%b ce1=%b sclk_ram=%b sclk_nor=%b sio_o=%h sio_oe=%h required 1 1 0 0 0 0",
               bus.ce0, bus.ce1, bus.sclk_ram, bus.sclk_nor, bus.sio_o, bus.sio_oe);
    end
    do_reset();
  endtask

  task automatic test_single_grant();
    do_reset();
    bus.req0 = 1'b1; bus.m0_ce_n = 1'b0; bus.m0_sclk = 1'b1; bus.m0_sio_oe = 4'hA;
    #1;
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.ce0 !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: gnt0=%b ce0=%b required 0 1 before the edge", bus.gnt0, bus.ce0);
    end
    cycle();
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.ce0 !== 1'b0 || bus.ce1 !== 1'b1 ||
        bus.sclk_nor !== 1'b0 || bus.sclk_ram !== 1'b1 || bus.sio_oe !== 4'hA) begin
      failures++;
      $display("FAIL single_grant: gnt0=%b gnt1=%b ce0=%b ce1=%b sclk_ram=%b sclk_nor=%b oe=%h required 1 0 0 1 1 0 a",
               bus.gnt0, bus.gnt1, bus.ce0, bus.ce1, bus.sclk_ram, bus.sclk_nor, bus.sio_oe);
    end
  endtask

  task automatic test_tie_gap();
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    cycle();
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL tie_first: gnt0=%b gnt1=%b required 1 0", bus.gnt0, bus.gnt1);
    end
    bus.req0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.busy !== 1'b1 || bus.ce0 !== 1'b1 || bus.ce1 !== 1'b1) begin
        failures++;
        $display("FAIL tie_gap%0d: gnt0=%b gnt1=%b busy=%b ce0=%b ce1=%b required 0 0 1 1 1",
                 i, bus.gnt0, bus.gnt1, bus.busy, bus.ce0, bus.ce1);
      end
      if (i == 0) begin
        checks++;
        if (bus_z.gnt0 !== 1'b0 || bus_z.gnt1 !== 1'b0 || bus_z.busy !== 1'b0) begin
          failures++;
          $display("FAIL gap0_idle: gnt0=%b gnt1=%b busy=%b required 0 0 0", bus_z.gnt0, bus_z.gnt1, bus_z.busy);
        end
      end else begin
        checks++;
        if (bus_z.gnt1 !== 1'b1 || bus_z.gnt0 !== 1'b0) begin
          failures++;
          $display("FAIL gap0_grant: gnt0=%b gnt1=%b required 0 1", bus_z.gnt0, bus_z.gnt1);
        end
      end
    end
    cycle();
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL tie_idle: busy=%b gnt1=%b required 0 0", bus.busy, bus.gnt1);
    end
    cycle();
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL tie_second: gnt0=%b gnt1=%b required 0 1", bus.gnt0, bus.gnt1);
    end
  endtask

  task automatic test_alternate();
    int who;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      who = -1;
      for (int n = 0; n < 8 && who < 0; n++) begin
        cycle();
        if (bus.gnt0 === 1'b1) who = 0;
        else if (bus.gnt1 === 1'b1) who = 1;
      end
      checks++;
      if (who != (r % 2)) begin
        failures++;
        $display("FAIL alternate_round%0d: granted master %0d required %0d", r, who, r % 2);
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      for (int n = 0; n < 8; n++) begin
        cycle();
        if (bus.busy === 1'b0) break;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL alternate_release%0d: busy=%b required 0 within budget", r, bus.busy);
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    bus.m1_sio_oe = 4'hF; bus.m1_sio_o = 4'h5; bus.m1_sclk = 1'b1;
    cycle();
    checks++;
    if (bus.sio_oe !== 4'h0 || bus.sio_o !== 4'h0 || bus.ce1 !== 1'b1 || bus.sclk_nor !== 1'b0) begin
      failures++;
      $display("FAIL err_pads: sio_oe=%h sio_o=%h ce1=%b sclk_nor=%b required 0 0 1 0",
               bus.sio_oe, bus.sio_o, bus.ce1, bus.sclk_nor);
    end
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL err_set: err=%b required 1", bus.err);
    end
    idle_inputs();
    repeat (3) cycle();
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b required 1", bus.err);
    end
    do_reset();
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err=%b required 0", bus.err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req1 = 1'b1; bus.m1_ce_n = 1'b0; bus.m1_sio_oe = 4'hF; bus.m1_sclk = 1'b1;
    cycle();
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.ce1 !== 1'b0 || bus.sio_oe !== 4'hF) begin
      failures++;
      $display("FAIL burst_own1: gnt1=%b ce1=%b sio_oe=%h required 1 0 f", bus.gnt1, bus.ce1, bus.sio_oe);
    end
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.ce1 !== 1'b1 || bus.sio_oe !== 4'h0 || bus.gnt1 !== 1'b0 || bus.sclk_nor !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: ce1=%b sio_oe=%h gnt1=%b sclk_nor=%b required 1 0 0 0",
               bus.ce1, bus.sio_oe, bus.gnt1, bus.sclk_nor);
    end
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    cycle();
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_tie: gnt0=%b gnt1=%b required 1 0", bus.gnt0, bus.gnt1);
    end
  endtask

  task automatic test_random();
    logic g0, g1, bz, er, c0, c1, sr, sn;
    logic [3:0] so, se;
    logic e_c0, e_c1, e_sr, e_sn;
    logic [3:0] e_so, e_se;
    int o;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) bus.req0 = ~bus.req0;
      if ($urandom_range(3) == 0) bus.req1 = ~bus.req1;
      if (bus.req0) begin
        bus.m0_ce_n = 1'($urandom_range(1)); bus.m0_sclk = 1'($urandom_range(1));
        bus.m0_sio_o = 4'($urandom); bus.m0_sio_oe = 4'($urandom);
      end else begin
        bus.m0_ce_n = 1'b1; bus.m0_sclk = 1'b0; bus.m0_sio_o = 4'h0; bus.m0_sio_oe = 4'h0;
      end
      if (bus.req1) begin
        bus.m1_ce_n = 1'($urandom_range(1)); bus.m1_sclk = 1'($urandom_range(1));
        bus.m1_sio_o = 4'($urandom); bus.m1_sio_oe = 4'($urandom);
      end else begin
        bus.m1_ce_n = 1'b1; bus.m1_sclk = 1'b0; bus.m1_sio_o = 4'h0; bus.m1_sio_oe = 4'h0;
      end
      cycle();
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin
          g0 = bus.gnt0; g1 = bus.gnt1; bz = bus.busy; er = bus.err; c0 = bus.ce0; c1 = bus.ce1;
          sr = bus.sclk_ram; sn = bus.sclk_nor; so = bus.sio_o; se = bus.sio_oe;
        end else begin
          g0 = bus_z.gnt0; g1 = bus_z.gnt1; bz = bus_z.busy; er = bus_z.err; c0 = bus_z.ce0; c1 = bus_z.ce1;
          sr = bus_z.sclk_ram; sn = bus_z.sclk_nor; so = bus_z.sio_o; se = bus_z.sio_oe;
        end
        o    = m_owner[k];
        e_c0 = (o == 0) ? bus.m0_ce_n : 1'b1;
        e_c1 = (o == 1) ? bus.m1_ce_n : 1'b1;
        e_sr = (o == 0) ? bus.m0_sclk : 1'b0;
        e_sn = (o == 1) ? bus.m1_sclk : 1'b0;
        e_so = (o == 0) ? bus.m0_sio_o  : (o == 1) ? bus.m1_sio_o  : 4'h0;
        e_se = (o == 0) ? bus.m0_sio_oe : (o == 1) ? bus.m1_sio_oe : 4'h0;
        checks++;
        if (g0 !== (o == 0) || g1 !== (o == 1) || bz !== (o >= 0 || m_gap[k] > 0) || er !== m_err[k]) begin
          failures++;
          $display("FAIL rand_ctrl inst%0d cyc%0d: gnt0=%b gnt1=%b busy=%b err=%b required %b %b %b %b",
                   k, n, g0, g1, bz, er, (o == 0), (o == 1), (o >= 0 || m_gap[k] > 0), m_err[k]);
        end
        checks++;
        if (c0 !== e_c0 || c1 !== e_c1 || sr !== e_sr || sn !== e_sn || so !== e_so || se !== e_se) begin
          failures++;
          $display("FAIL rand_pads inst%0d cyc%0d: ce0=%b ce1=%b sr=%b sn=%b so=%h se=%h required %b %b %b %b %h %h",
                   k, n, c0, c1, sr, sn, so, se, e_c0, e_c1, e_sr, e_sn, e_so, e_se);
        end
        checks++;
        if ((g0 & g1) !== 1'b0) begin
          failures++;
          $display("FAIL rand_exclusive inst%0d cyc%0d: gnt0=%b gnt1=%b required not both", k, n, g0, g1);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_grant();
    test_tie_gap();
    test_alternate();
    test_err();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
